mem_port_arbiter: RTL

Shares one single-port unified instruction/data memory between the pipeline's fetch stage and memory stage. Each side gets a request/ready handshake. The block drives the shared memory through a req/ack handshake that tolerates variable latency. It produces per-side stall signals that feed the hazard unit alongside its existing stall_F/stall_D logic. Data accesses win by default, and a starvation limiter guarantees that fetch makes forward progress.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data, shared-memory and hazard signals around the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_i;
    logic              stall_d;
    logic              timeout_err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
               stall_i, stall_d, timeout_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
               stall_i, stall_d, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data, data first with a fetch starvation limit
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 3,
    parameter int MAX_WAIT   = 15
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_t;

    state_t            state, next;
    logic [WW-1:0]     wait_cnt;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, i_rdata, d_rdata;
    logic              mem_req, mem_we, i_ready, d_ready, timeout_err;
    logic              grant_d, grant_i, ack, expire, fin;

    assign fin = ack || expire;

    // Arbitrate in IDLE outside ready cycles (the finished requester still holds req then); detect ack or timeout while waiting
    always_comb begin
        next    = state;
        grant_d = 1'b0;
        grant_i = 1'b0;
        ack     = 1'b0;
        expire  = 1'b0;
        case (state)
            IDLE: begin
                if (!i_ready && !d_ready) begin
                    grant_d = bus.d_req && (!bus.i_req || starve_cnt < STARVE_MAX);
                    grant_i = bus.i_req && !grant_d;
                end
                next = grant_d ? D_WAIT : grant_i ? I_WAIT : IDLE;
            end
            D_WAIT, I_WAIT: begin
                ack    = bus.mem_ack;
                expire = !bus.mem_ack && wait_cnt == WAIT_MAX;
                next   = (ack || expire) ? IDLE : state;
            end
            default: next = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    // Memory-side request: raised on grant, fields latched once and held for the whole access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= next != IDLE;
            if (grant_d || grant_i) begin
                mem_addr  <= grant_d ? bus.d_addr : bus.i_addr;
                mem_we    <= grant_d && bus.d_we;
                mem_wdata <= grant_d ? bus.d_wdata : '0;
            end
        end
    end

    // Requester-side completion: one-cycle ready, read data captured on ack or zeroed on abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_ready     <= 1'b0;
            d_ready     <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            i_ready     <= fin && state == I_WAIT;
            d_ready     <= fin && state == D_WAIT;
            timeout_err <= timeout_err || expire;
            if (fin && state == I_WAIT) i_rdata <= ack ? bus.mem_rdata : '0;
            if (fin && state == D_WAIT) d_rdata <= ack ? bus.mem_rdata : '0;
        end
    end

    // Wait-cycle counter for the timeout, and the run of data grants taken while fetch was waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            wait_cnt   <= next == IDLE ? '0 : wait_cnt + 1'b1;
            starve_cnt <= (!bus.i_req || grant_i) ? '0
                        : (grant_d && starve_cnt < STARVE_MAX) ? starve_cnt + 1'b1 : starve_cnt;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.i_ready     = i_ready;
    assign bus.d_ready     = d_ready;
    assign bus.i_rdata     = i_rdata;
    assign bus.d_rdata     = d_rdata;
    assign bus.timeout_err = timeout_err;
    assign bus.stall_i     = bus.i_req & ~i_ready;
    assign bus.stall_d     = bus.d_req & ~d_ready;
endmodule
